// File: rtl/rx_frame_sequencer_if.sv
// Bus bundle between the RX frame sequencer, the UART RX FIFO and the image buffer.
// The sequencer connects through the master modport; the FIFO/buffer side through slave.
interface rx_frame_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              empty;
  logic [7:0]        pop_data;
  logic              pop;
  logic              pix_ready;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       rgb_data;
  logic              frame_start;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  modport master (
    input  empty, pop_data, pix_ready,
    output pop, pix_we, pix_addr, rgb_data, frame_start, frame_done, frame_err, busy
  );

  modport slave (
    output empty, pop_data, pix_ready,
    input  pop, pix_we, pix_addr, rgb_data, frame_start, frame_done, frame_err, busy
  );
endinterface

// File: rtl/rx_frame_sequencer.sv
// Drains the UART RX FIFO, locks onto SOF/EOF framing and writes 3-byte RGB pixels to the image buffer.
// Optional per-frame XOR checksum byte before EOF when RX_FRAME_CHECKSUM_EN is defined.
module rx_frame_sequencer #(
  parameter int         FRAME_PIXELS = 4096,
  parameter int         ADDR_W       = 12,
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter logic [7:0] EOF_BYTE     = 8'h5A
) (
  input  logic                   clk,
  input  logic                   reset,
  rx_frame_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_BYTES,
    S_WRITE,
`ifdef RX_FRAME_CHECKSUM_EN
    S_CHK,
`endif
    S_TAIL
  } state_t;

  // NOTE: one spare bit so the post-increment after the last pixel can never wrap to 0.
  localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W+1)'(FRAME_PIXELS - 1);

  state_t          state_q;
  logic [1:0]      byte_cnt_q;
  logic [ADDR_W:0] pix_cnt_q;
  logic [7:0]      r_q;
  logic [7:0]      g_q;
  logic [23:0]     rgb_q;
  logic            start_q;
  logic            done_q;
  logic            err_q;
  logic            pop_d;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]      chk_q;
`endif

  // NOTE: pop is combinational on empty so a fall-through byte is consumed in the cycle it is seen;
  // it is gated by reset so nothing is lost from the FIFO while reset is held.
  always_comb begin
    pop_d = 1'b0;
    if (!reset && !bus.empty && state_q != S_WRITE) pop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HUNT;
      byte_cnt_q <= '0;
      pix_cnt_q  <= '0;
      r_q        <= '0;
      g_q        <= '0;
      rgb_q      <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_HUNT: begin
          if (pop_d && bus.pop_data == SOF_BYTE) begin
            start_q    <= 1'b1;
            pix_cnt_q  <= '0;
            byte_cnt_q <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
            chk_q      <= '0;
`endif
            state_q    <= S_BYTES;
          end
        end
        S_BYTES: begin
          if (pop_d) begin
`ifdef RX_FRAME_CHECKSUM_EN
            chk_q <= chk_q ^ bus.pop_data;
`endif
            case (byte_cnt_q)
              2'd0: begin
                r_q        <= bus.pop_data;
                byte_cnt_q <= 2'd1;
              end
              2'd1: begin
                g_q        <= bus.pop_data;
                byte_cnt_q <= 2'd2;
              end
              default: begin
                rgb_q      <= {r_q, g_q, bus.pop_data};
                byte_cnt_q <= 2'd0;
                state_q    <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (bus.pix_ready) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_cnt_q == LAST_PIX) begin
`ifdef RX_FRAME_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q <= S_TAIL;
`endif
            end else begin
              state_q <= S_BYTES;
            end
          end
        end
`ifdef RX_FRAME_CHECKSUM_EN
        S_CHK: begin
          if (pop_d) begin
            if (bus.pop_data == chk_q) begin
              state_q <= S_TAIL;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_HUNT;
            end
          end
        end
`endif
        S_TAIL: begin
          if (pop_d) begin
            if (bus.pop_data == EOF_BYTE) done_q <= 1'b1;
            else                          err_q  <= 1'b1;
            state_q <= S_HUNT;
          end
        end
        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign bus.pop         = pop_d;
  assign bus.pix_we      = (state_q == S_WRITE);
  assign bus.pix_addr    = pix_cnt_q[ADDR_W-1:0];
  assign bus.rgb_data    = rgb_q;
  assign bus.frame_start = start_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = (state_q != S_HUNT);

endmodule
